axi_slave_mem_plug: RTL and testbench
=====================================

AXI_SLAVE_MEM_PLUG -- requirements
Module: axi_slave_mem_plug

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter AXI_ID_WIDTH, default 3, transaction ID width.
REQ-003 Parameter MEM_WORDS, default 32, number of 64-bit memory words (power of 2, >=2); data width is fixed at 64 bits.
REQ-004 axi_aclk  in  1  the single clock; all logic on rising edge.
REQ-005 axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 axi_slave_aw_valid  in  1  write-address valid.
REQ-007 axi_slave_aw_ready  out  1  write-address ready.
REQ-008 axi_slave_aw_addr  in  AXI_ADDR_WIDTH  burst start byte address.
REQ-009 axi_slave_aw_len  in  8  beats minus one.
REQ-010 axi_slave_aw_id  in  AXI_ID_WIDTH  write ID.
REQ-011 axi_slave_w_valid  in  1  write-data valid.
REQ-012 axi_slave_w_ready  out  1  write-data ready.
REQ-013 axi_slave_w_data  in  64  write data.
REQ-014 axi_slave_w_strb  in  8  byte enables.
REQ-015 axi_slave_w_last  in  1  final beat marker.
REQ-016 axi_slave_b_valid  out  1  write-response valid.
REQ-017 axi_slave_b_ready  in  1  write-response ready.
REQ-018 axi_slave_b_resp  out  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-019 axi_slave_b_id  out  AXI_ID_WIDTH  echoes latched aw_id.
REQ-020 axi_slave_ar_valid  in  1  read-address valid.
REQ-021 axi_slave_ar_ready  out  1  read-address ready.
REQ-022 axi_slave_ar_addr  in  AXI_ADDR_WIDTH  burst start byte address.
REQ-023 axi_slave_ar_len  in  8  beats minus one.
REQ-024 axi_slave_ar_id  in  AXI_ID_WIDTH  read ID.
REQ-025 axi_slave_r_valid  out  1  read-data valid.
REQ-026 axi_slave_r_ready  in  1  read-data ready.
REQ-027 axi_slave_r_data  out  64  read data.
REQ-028 axi_slave_r_resp  out  2  per-beat response, encoding as b_resp.
REQ-029 axi_slave_r_last  out  1  final read beat.
REQ-030 axi_slave_r_id  out  AXI_ID_WIDTH  echoes latched ar_id.

Function
REQ-031 Storage: MEM_WORDS x 64 flops; word index = addr[3+log2(MEM_WORDS)-1:3]; addr[2:0] ignored; burst type INCR only, +8 bytes per beat; size fixed 8 bytes.
REQ-032 Out-of-range beat (addr[AXI_ADDR_WIDTH-1:3] >= MEM_WORDS, including after increment): write dropped, read data 64'h0, resp SLVERR; no index wrap.
REQ-033 Write FSM W_IDLE/W_DATA/W_RESP: W_IDLE aw_ready=1; AW handshake latches addr, len, id, clears beat count and error flag -> W_DATA.
REQ-034 W_DATA: w_ready=1; each W handshake writes bytes with strb bit set (strb=0 writes nothing), addr+=8, count+=1; beat with w_last=1 -> W_RESP.
REQ-035 Beat count != len+1 at w_last sets error flag; beats beyond len+1 are not written; any out-of-range beat sets error flag.
REQ-036 W_RESP: b_valid=1, b_resp=SLVERR if error flag else OKAY, b_id=latched id, held stable until b_ready -> W_IDLE; aw_ready returns the next cycle.
REQ-037 Read FSM R_IDLE/R_DATA: R_IDLE ar_ready=1; AR handshake latches addr, len, id, count=0, loads r_data register from first word -> R_DATA; r_valid high the cycle after AR handshake.
REQ-038 R_DATA: r_valid=1; r_data/r_resp/r_last/r_id stable while r_valid && !r_ready; r_last=1 iff count==len.
REQ-039 Read handshake with r_last=0: addr+=8, count+=1, r_data register reloads next word in the same edge; handshake with r_last=1 -> R_IDLE.
REQ-040 Read and write FSMs independent; one outstanding burst per direction; write and read capture of same word on same edge: read captures pre-write value.
REQ-041 len=0 is a single beat; len=255 is 256 beats; count is 9 bits, no overflow.

Reset
REQ-042 aresetn low: both FSMs to IDLE, memory cleared to 0, all latched addr/len/id/count/flags 0; outputs: aw_ready=ar_ready=1, w_ready=0, b_valid=r_valid=r_last=0, b_resp=r_resp=0, b_id=r_id=0, r_data=0.
REQ-043 Reset mid-burst aborts it with no response; the burst's already-written beats are cleared by the reset.

Verification
REQ-044 AW addr 0x10 len 0 id 5, W data 0x1122334455667788 strb 0xFF last -> B OKAY id 5; AR addr 0x10 len 0 -> r_data 0x1122334455667788, r_last=1, OKAY.
REQ-045 Write addr 0x0 len 3 data 1..4 strb 0xFF, read addr 0x0 len 3 with r_ready toggling every cycle -> data 1,2,3,4, r_last only on 4th beat, data stable while stalled.
REQ-046 Write addr 0x8 strb 0x0F data 0xAAAAAAAA_BBBBBBBB over prior 0xFFFFFFFF_FFFFFFFF -> read returns 0xFFFFFFFF_BBBBBBBB.
REQ-047 MEM_WORDS=32: write addr 0xF8 len 1 -> word 31 written, second beat dropped, B SLVERR; read addr 0xF8 len 1 -> beat0 OKAY, beat1 data 0 SLVERR.
REQ-048 Write len 2 with w_last on 2nd beat -> B SLVERR; b_ready held low 5 cycles -> b_valid held, aw_ready low until handshake.
REQ-049 Reset asserted during read beat 2 of 4 -> r_valid 0 immediately, ar_ready=1, subsequent read of any word returns 0.

Source files
------------

// File: rtl/axi_slave_mem_plug.sv
// -----------------------------------------------------------------------------
// axi_slave_mem_plug
// Small AXI4 slave backed by a flop memory of MEM_WORDS x 64-bit words.
// INCR bursts only, fixed 8-byte beats. Beats whose word address lies beyond
// the memory are dropped on write and return zero data on read, both with
// SLVERR. Read and write channels run independent FSMs, one burst each.
//
// Ports:
//   axi_aclk / axi_aresetn        clock, async active-low reset
//   axi_slave_aw_* / w_* / b_*    write address, data, response channels
//   axi_slave_ar_* / r_*          read address and data channels
// -----------------------------------------------------------------------------
module axi_slave_mem_plug #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 3,
    parameter int unsigned MEM_WORDS      = 32
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    // write address
    input  logic                      axi_slave_aw_valid,
    output logic                      axi_slave_aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr,
    input  logic [7:0]                axi_slave_aw_len,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slave_aw_id,
    // write data
    input  logic                      axi_slave_w_valid,
    output logic                      axi_slave_w_ready,
    input  logic [63:0]               axi_slave_w_data,
    input  logic [7:0]                axi_slave_w_strb,
    input  logic                      axi_slave_w_last,
    // write response
    output logic                      axi_slave_b_valid,
    input  logic                      axi_slave_b_ready,
    output logic [1:0]                axi_slave_b_resp,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id,
    // read address
    input  logic                      axi_slave_ar_valid,
    output logic                      axi_slave_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr,
    input  logic [7:0]                axi_slave_ar_len,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slave_ar_id,
    // read data
    output logic                      axi_slave_r_valid,
    input  logic                      axi_slave_r_ready,
    output logic [63:0]               axi_slave_r_data,
    output logic [1:0]                axi_slave_r_resp,
    output logic                      axi_slave_r_last,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id
);

    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned HI_LSB = 3 + IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(8);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

    // A beat is in range when every address bit above the word index is zero;
    // MEM_WORDS is a power of two so this equals addr[AW-1:3] < MEM_WORDS.
    function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return addr[AXI_ADDR_WIDTH-1:HI_LSB] == '0;
    endfunction

    logic [63:0] r_mem [MEM_WORDS];

    // ---------------------------------------------------------------- write
    wr_state_e                 r_wr_state;
    logic [AXI_ADDR_WIDTH-1:0] r_wr_addr;
    logic [7:0]                r_wr_len;
    logic [AXI_ID_WIDTH-1:0]   r_wr_id;
    logic [8:0]                r_wr_cnt;
    logic                      r_wr_err;
    logic                      r_aw_ready;
    logic                      r_w_ready;
    logic                      r_b_valid;
    logic [1:0]                r_b_resp;

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_wr_inrange;
    logic                      w_wr_keep;
    logic                      w_wr_err_next;
    logic [IDX_W-1:0]          w_wr_idx;

    assign w_aw_hs      = axi_slave_aw_valid & r_aw_ready;
    assign w_w_hs       = axi_slave_w_valid & r_w_ready;
    assign w_wr_inrange = in_range(r_wr_addr);
    // Beats past len+1 are not stored even when in range.
    assign w_wr_keep    = w_wr_inrange && (r_wr_cnt <= {1'b0, r_wr_len});
    assign w_wr_idx     = r_wr_addr[HI_LSB-1:3];
    assign w_wr_err_next = r_wr_err | ~w_wr_inrange |
                           (axi_slave_w_last && (r_wr_cnt != {1'b0, r_wr_len}));

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wr_state <= W_IDLE;
            r_wr_addr  <= '0;
            r_wr_len   <= '0;
            r_wr_id    <= '0;
            r_wr_cnt   <= '0;
            r_wr_err   <= 1'b0;
            r_aw_ready <= 1'b1;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
        end else begin
            unique case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wr_addr  <= axi_slave_aw_addr;
                        r_wr_len   <= axi_slave_aw_len;
                        r_wr_id    <= axi_slave_aw_id;
                        r_wr_cnt   <= '0;
                        r_wr_err   <= 1'b0;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b1;
                        r_wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_wr_addr <= r_wr_addr + BEAT_BYTES;
                        // Saturate so a runaway burst can never alias len+1.
                        r_wr_cnt  <= (r_wr_cnt == 9'h1FF) ? r_wr_cnt : r_wr_cnt + 9'd1;
                        r_wr_err  <= w_wr_err_next;
                        if (axi_slave_w_last) begin
                            r_w_ready  <= 1'b0;
                            r_b_valid  <= 1'b1;
                            r_b_resp   <= w_wr_err_next ? RESP_SLVERR : RESP_OKAY;
                            r_wr_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_slave_b_ready) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_w_hs && w_wr_keep) begin
            for (int b = 0; b < 8; b++) begin
                if (axi_slave_w_strb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= axi_slave_w_data[8*b +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------------- read
    rd_state_e                 r_rd_state;
    logic [AXI_ADDR_WIDTH-1:0] r_rd_addr;
    logic [7:0]                r_rd_len;
    logic [AXI_ID_WIDTH-1:0]   r_rd_id;
    logic [8:0]                r_rd_cnt;
    logic                      r_ar_ready;
    logic                      r_r_valid;
    logic [63:0]               r_r_data;
    logic [1:0]                r_r_resp;
    logic                      r_r_last;

    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic [AXI_ADDR_WIDTH-1:0] w_rd_next_addr;
    logic [8:0]                w_rd_cnt_inc;

    assign w_ar_hs        = axi_slave_ar_valid & r_ar_ready;
    assign w_r_hs         = r_r_valid & axi_slave_r_ready;
    assign w_rd_next_addr = r_rd_addr + BEAT_BYTES;
    assign w_rd_cnt_inc   = r_rd_cnt + 9'd1;

    // Memory is sampled with non-blocking semantics, so a read load on the
    // same edge as a write to that word sees the pre-write value.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_rd_state <= R_IDLE;
            r_rd_addr  <= '0;
            r_rd_len   <= '0;
            r_rd_id    <= '0;
            r_rd_cnt   <= '0;
            r_ar_ready <= 1'b1;
            r_r_valid  <= 1'b0;
            r_r_data   <= '0;
            r_r_resp   <= RESP_OKAY;
            r_r_last   <= 1'b0;
        end else begin
            unique case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rd_addr  <= axi_slave_ar_addr;
                        r_rd_len   <= axi_slave_ar_len;
                        r_rd_id    <= axi_slave_ar_id;
                        r_rd_cnt   <= '0;
                        r_r_data   <= in_range(axi_slave_ar_addr) ?
                                      r_mem[axi_slave_ar_addr[HI_LSB-1:3]] : 64'h0;
                        r_r_resp   <= in_range(axi_slave_ar_addr) ? RESP_OKAY : RESP_SLVERR;
                        r_r_last   <= (axi_slave_ar_len == 8'd0);
                        r_r_valid  <= 1'b1;
                        r_ar_ready <= 1'b0;
                        r_rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_r_last) begin
                            r_r_valid  <= 1'b0;
                            r_r_last   <= 1'b0;
                            r_ar_ready <= 1'b1;
                            r_rd_state <= R_IDLE;
                        end else begin
                            r_rd_addr <= w_rd_next_addr;
                            r_rd_cnt  <= w_rd_cnt_inc;
                            r_r_data  <= in_range(w_rd_next_addr) ?
                                         r_mem[w_rd_next_addr[HI_LSB-1:3]] : 64'h0;
                            r_r_resp  <= in_range(w_rd_next_addr) ? RESP_OKAY : RESP_SLVERR;
                            r_r_last  <= (w_rd_cnt_inc == {1'b0, r_rd_len});
                        end
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign axi_slave_aw_ready = r_aw_ready;
    assign axi_slave_w_ready  = r_w_ready;
    assign axi_slave_b_valid  = r_b_valid;
    assign axi_slave_b_resp   = r_b_resp;
    assign axi_slave_b_id     = r_wr_id;
    assign axi_slave_ar_ready = r_ar_ready;
    assign axi_slave_r_valid  = r_r_valid;
    assign axi_slave_r_data   = r_r_data;
    assign axi_slave_r_resp   = r_r_resp;
    assign axi_slave_r_last   = r_r_last;
    assign axi_slave_r_id     = r_rd_id;

endmodule

// File: tb/tb_axi_slave_mem_plug.sv
// -----------------------------------------------------------------------------
// tb_axi_slave_mem_plug
// Directed and randomized bursts against a word-array reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi_slave_mem_plug;

    localparam int AW = 32;
    localparam int IW = 3;
    localparam int MW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          aw_valid, aw_ready;
    logic [AW-1:0] aw_addr;
    logic [7:0]    aw_len;
    logic [IW-1:0] aw_id;
    logic          w_valid, w_ready, w_last;
    logic [63:0]   w_data;
    logic [7:0]    w_strb;
    logic          b_valid, b_ready;
    logic [1:0]    b_resp;
    logic [IW-1:0] b_id;
    logic          ar_valid, ar_ready;
    logic [AW-1:0] ar_addr;
    logic [7:0]    ar_len;
    logic [IW-1:0] ar_id;
    logic          r_valid, r_ready, r_last;
    logic [63:0]   r_data;
    logic [1:0]    r_resp;
    logic [IW-1:0] r_id;

    always #5 clk = ~clk;

    axi_slave_mem_plug #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_ID_WIDTH  (IW),
        .MEM_WORDS     (MW)
    ) u_dut (
        .axi_aclk          (clk),
        .axi_aresetn       (rst_n),
        .axi_slave_aw_valid(aw_valid),
        .axi_slave_aw_ready(aw_ready),
        .axi_slave_aw_addr (aw_addr),
        .axi_slave_aw_len  (aw_len),
        .axi_slave_aw_id   (aw_id),
        .axi_slave_w_valid (w_valid),
        .axi_slave_w_ready (w_ready),
        .axi_slave_w_data  (w_data),
        .axi_slave_w_strb  (w_strb),
        .axi_slave_w_last  (w_last),
        .axi_slave_b_valid (b_valid),
        .axi_slave_b_ready (b_ready),
        .axi_slave_b_resp  (b_resp),
        .axi_slave_b_id    (b_id),
        .axi_slave_ar_valid(ar_valid),
        .axi_slave_ar_ready(ar_ready),
        .axi_slave_ar_addr (ar_addr),
        .axi_slave_ar_len  (ar_len),
        .axi_slave_ar_id   (ar_id),
        .axi_slave_r_valid (r_valid),
        .axi_slave_r_ready (r_ready),
        .axi_slave_r_data  (r_data),
        .axi_slave_r_resp  (r_resp),
        .axi_slave_r_last  (r_last),
        .axi_slave_r_id    (r_id)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain word array, beat i of a burst hits word (addr>>3)+i.
    logic [63:0] mdl [MW];
    logic [63:0] wd_q [$];
    logic [7:0]  ws_q [$];

    task automatic mdl_clear();
        for (int i = 0; i < MW; i++) mdl[i] = '0;
    endtask

    // Writes the beats queued in wd_q/ws_q. Must be entered on a falling edge.
    task automatic do_write(input logic [31:0] addr, input int len, input int id,
                            input int bhold, input bit gaps);
        int nb;
        int to;
        bit err;
        longint wi;
        logic [63:0] d;
        logic [7:0]  s;
        nb  = wd_q.size();
        err = (nb != len + 1);
        for (int i = 0; i < nb; i++) begin
            wi = longint'(addr >> 3) + i;
            d  = wd_q[i];
            s  = ws_q[i];
            if (wi >= MW) err = 1'b1;
            else if (i <= len)
                for (int b = 0; b < 8; b++) if (s[b]) mdl[wi][8*b +: 8] = d[8*b +: 8];
        end
        aw_valid = 1'b1; aw_addr = addr; aw_len = len[7:0]; aw_id = id[IW-1:0];
        to = 0;
        while (!aw_ready && to < 100) begin @(negedge clk); to++; end
        if (to >= 100) check("aw_timeout", 64'd0, 64'd1);
        @(negedge clk);
        aw_valid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                w_valid = 1'b0;
                @(negedge clk);
            end
            w_valid = 1'b1; w_data = wd_q[i]; w_strb = ws_q[i]; w_last = (i == nb - 1);
            to = 0;
            while (!w_ready && to < 100) begin @(negedge clk); to++; end
            if (to >= 100) check("w_timeout", 64'd0, 64'd1);
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        to = 0;
        while (!b_valid && to < 100) begin @(negedge clk); to++; end
        check("b_valid", 64'(b_valid), 64'd1);
        for (int k = 0; k < bhold; k++) begin
            check("b_valid_held", 64'(b_valid), 64'd1);
            check("aw_ready_low", 64'(aw_ready), 64'd0);
            @(negedge clk);
        end
        check("b_resp", 64'(b_resp), err ? 64'd2 : 64'd0);
        check("b_id", 64'(b_id), 64'(id[IW-1:0]));
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check("b_valid_drop", 64'(b_valid), 64'd0);
        check("aw_ready_back", 64'(aw_ready), 64'd1);
        wd_q.delete();
        ws_q.delete();
    endtask

    // mode: 0 random r_ready, 1 r_ready toggling (stall first), 2 always ready.
    task automatic do_read(input logic [31:0] addr, input int len, input int id, input int mode);
        int to;
        int i;
        int cyc;
        bit rdy;
        bit tog;
        bit stall;
        longint wi;
        logic [63:0] p_data;
        logic [1:0]  p_resp;
        logic        p_last;
        ar_valid = 1'b1; ar_addr = addr; ar_len = len[7:0]; ar_id = id[IW-1:0];
        to = 0;
        while (!ar_ready && to < 100) begin @(negedge clk); to++; end
        if (to >= 100) check("ar_timeout", 64'd0, 64'd1);
        @(negedge clk);
        ar_valid = 1'b0;
        check("r_valid_first", 64'(r_valid), 64'd1);
        i = 0; cyc = 0; tog = 1'b0; stall = 1'b0;
        p_data = '0; p_resp = '0; p_last = 1'b0;
        while (i <= len && cyc < 2000) begin
            if (stall) begin
                check("r_stable_data", r_data, p_data);
                check("r_stable_resp", 64'(r_resp), 64'(p_resp));
                check("r_stable_last", 64'(r_last), 64'(p_last));
            end
            rdy = (mode == 2) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            r_ready = rdy;
            if (r_valid && rdy) begin
                wi = longint'(addr >> 3) + i;
                check("r_data", r_data, (wi < MW) ? mdl[wi] : 64'h0);
                check("r_resp", 64'(r_resp), (wi < MW) ? 64'd0 : 64'd2);
                check("r_last", 64'(r_last), 64'(i == len));
                check("r_id", 64'(r_id), 64'(id[IW-1:0]));
                i++;
                stall = 1'b0;
            end else begin
                stall = r_valid;
                p_data = r_data; p_resp = r_resp; p_last = r_last;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) check("r_timeout", 64'd0, 64'd1);
        r_ready = 1'b0;
        check("r_valid_end", 64'(r_valid), 64'd0);
        check("ar_ready_end", 64'(ar_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int len;
        int nb;
        logic [31:0] a;
        aw_valid = 0; aw_addr = 0; aw_len = 0; aw_id = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_addr = 0; ar_len = 0; ar_id = 0; r_ready = 0;
        mdl_clear();
        repeat (3) @(negedge clk);
        check("rst_aw_ready", 64'(aw_ready), 64'd1);
        check("rst_ar_ready", 64'(ar_ready), 64'd1);
        check("rst_w_ready", 64'(w_ready), 64'd0);
        check("rst_b_valid", 64'(b_valid), 64'd0);
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_r_last", 64'(r_last), 64'd0);
        check("rst_resp", 64'({b_resp, r_resp}), 64'd0);
        check("rst_ids", 64'({b_id, r_id}), 64'd0);
        check("rst_r_data", r_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat round trip.
        wd_q.push_back(64'h1122334455667788); ws_q.push_back(8'hFF);
        do_write(32'h10, 0, 5, 0, 0);
        do_read(32'h10, 0, 2, 2);

        // Four-beat burst, reader stalls every other cycle.
        for (int k = 1; k <= 4; k++) begin wd_q.push_back(64'(k)); ws_q.push_back(8'hFF); end
        do_write(32'h0, 3, 1, 0, 0);
        do_read(32'h0, 3, 3, 1);

        // Partial strobe merge.
        wd_q.push_back(64'hFFFFFFFF_FFFFFFFF); ws_q.push_back(8'hFF);
        do_write(32'h8, 0, 2, 0, 0);
        wd_q.push_back(64'hAAAAAAAA_BBBBBBBB); ws_q.push_back(8'h0F);
        do_write(32'h8, 0, 2, 0, 0);
        do_read(32'h8, 0, 4, 2);

        // Burst running off the top of memory.
        wd_q.push_back(64'hCAFE0000_0000BEEF); ws_q.push_back(8'hFF);
        wd_q.push_back(64'hDEADDEAD_DEADDEAD); ws_q.push_back(8'hFF);
        do_write(32'hF8, 1, 6, 0, 0);
        do_read(32'hF8, 1, 6, 2);

        // Early w_last, response held off for five cycles.
        wd_q.push_back(64'h0123456789ABCDEF); ws_q.push_back(8'hFF);
        wd_q.push_back(64'hFEDCBA9876543210); ws_q.push_back(8'hFF);
        do_write(32'h20, 2, 7, 5, 0);
        do_read(32'h20, 2, 7, 0);

        // Randomized bursts, including short/long W bursts and out-of-range starts.
        for (int t = 0; t < 40; t++) begin
            a   = 32'($urandom_range(0, MW * 8 + 40));
            len = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 0) begin
                nb = len + 1;
                if ($urandom_range(0, 4) == 0) nb = (len > 0) ? len : len + 2;
                for (int k = 0; k < nb; k++) begin
                    wd_q.push_back({$urandom, $urandom});
                    ws_q.push_back(8'($urandom));
                end
                do_write(a, len, $urandom_range(0, 7), $urandom_range(0, 3), 1);
            end else begin
                do_read(a, len, $urandom_range(0, 7), 0);
            end
        end

        // Maximum length bursts.
        for (int k = 0; k < 256; k++) begin
            wd_q.push_back({$urandom, $urandom}); ws_q.push_back(8'hFF);
        end
        do_write(32'h0, 255, 3, 0, 0);
        do_read(32'h0, 255, 4, 2);

        // Reset in the middle of a read burst.
        ar_valid = 1'b1; ar_addr = 32'h0; ar_len = 8'd3; ar_id = 3'd1;
        @(negedge clk);
        ar_valid = 1'b0;
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_r_valid", 64'(r_valid), 64'd0);
        check("mid_rst_ar_ready", 64'(ar_ready), 64'd1);
        check("mid_rst_r_data", r_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_clear();
        @(negedge clk);
        do_read(32'h0, 7, 0, 2);
        for (int t = 0; t < 4; t++) do_read(32'($urandom_range(0, MW * 8 - 8)), 3, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
